rf_scoreboard: RTL and testbench

//  Parametrised register file with a per-register pending-write scoreboard for the pipelined CPU.
//  - Replaces the fixed 8x16 datapath register file.
//  - Provides NRD asynchronous read ports and one write port with high-half-only write mode.
//  - Per-register pending-write counters let decode detect RAW hazards and stall issue.

---
 rtl/rf_scoreboard_if.sv | 31 +++
 rtl/rf_scoreboard.sv | 97 +++++++++
 tb/tb_rf_scoreboard.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rf_scoreboard_if.sv
// Register-file scoreboard port bundle: read ports, issue tracking, writeback.
// master drives requests; slave (the register file) returns data and status.
interface rf_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] i_rd_addr;
  logic [NRD*DATA_W-1:0] o_rd_data;
  logic [NRD-1:0]        o_rd_busy;
  logic                  i_issue_en;
  logic [ADDR_W-1:0]     i_issue_addr;
  logic                  o_issue_stall;
  logic                  i_wr_en;
  logic [ADDR_W-1:0]     i_wr_addr;
  logic [DATA_W-1:0]     i_wr_data;
  logic                  i_wr_only_high;
  logic                  o_err;

  modport master (
    output i_rd_addr, i_issue_en, i_issue_addr,
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_only_high,
    input  o_rd_data, o_rd_busy, o_issue_stall, o_err
  );

  modport slave (
    input  i_rd_addr, i_issue_en, i_issue_addr,
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_only_high,
    output o_rd_data, o_rd_busy, o_issue_stall, o_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with per-register pending-write counters for RAW stalls.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rf_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int ADDR_W   = 3,
  parameter int NRD      = 2,
  parameter int PEND_MAX = 3
) (
  input logic           clk,
  input logic           rst,
  rf_scoreboard_if.slave bus
);
  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int HW = DATA_W / 2;
  localparam logic [PW-1:0] PMAX = PW'(PEND_MAX);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0][PW-1:0]     pend;
  logic                         err_q;

  logic [NREGS-1:0]      iss_sel;
  logic [NREGS-1:0]      wr_sel;
  logic [NREGS-1:0]      pz;
  logic                  stall;
  logic [DATA_W-1:0]     wr_val;
  logic                  err_set;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  // Out-of-range addresses match no register, so they are ignored.
  always_comb begin
    iss_sel = '0;
    wr_sel  = '0;
    pz      = '0;
    stall   = 1'b0;
    wr_val  = bus.i_wr_data;
    for (int r = 0; r < NREGS; r++) begin
      pz[r] = (pend[r] == '0);
      if (bus.i_issue_addr == ADDR_W'(r)) begin
        iss_sel[r] = 1'b1;
        stall      = (pend[r] == PMAX);
      end
      if (bus.i_wr_addr == ADDR_W'(r)) begin
        wr_sel[r] = bus.i_wr_en;
        if (bus.i_wr_only_high)
          wr_val = {bus.i_wr_data[DATA_W-1:HW],
                    regs[r][HW-1:0]};
      end
    end
    iss_sel = iss_sel & {NREGS{bus.i_issue_en & ~stall}};
    err_set = |(wr_sel & ~iss_sel & pz);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs  <= '0;
      pend  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_sel[r])
          regs[r] <= wr_val;
        if (iss_sel[r] && !wr_sel[r])
          pend[r] <= pend[r] + PW'(1);
        else if (wr_sel[r] && !iss_sel[r] && !pz[r])
          pend[r] <= pend[r] - PW'(1);
      end
      if (err_set)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.i_rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          rd_data[k*DATA_W +: DATA_W] = regs[r];
          rd_busy[k] = !pz[r];
`ifdef RF_BYPASS_EN
          if (wr_sel[r]) begin
            rd_data[k*DATA_W +: DATA_W] = wr_val;
            rd_busy[k] = (pend[r] > PW'(1));
          end
`endif
        end
      end
    end
  end

  assign bus.o_rd_data     = rd_data;
  assign bus.o_rd_busy     = rd_busy;
  assign bus.o_issue_stall = stall;
  assign bus.o_err         = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Table-driven bench for rf_scoreboard; expected combinational outputs
// are queued as each vector is driven and compared before the clock edge.
module tb_rf_scoreboard;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [2:0]  ra0, ra1;
    logic        ie;
    logic [2:0]  ia;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        hi;
    logic [15:0] d0, d1;
    logic [1:0]  b;
    logic        s, e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  rf_scoreboard_if #(.DATA_W(16), .ADDR_W(3), .NRD(2)) bus ();

  rf_scoreboard #(
    .DATA_W(16), .NREGS(8), .ADDR_W(3), .NRD(2), .PEND_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [2:0] ra0, ra1, input logic ie, input logic [2:0] ia,
    input logic we, input logic [2:0] wa, input logic [15:0] wd,
    input logic hi, input logic [15:0] d0, d1, input logic [1:0] b,
    input logic s, e);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.ie = ie; v.ia = ia;
    v.we = we; v.wa = wa; v.wd = wd; v.hi = hi;
    v.d0 = d0; v.d1 = d1; v.b = b; v.s = s; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_rd_addr      = {v.ra1, v.ra0};
    bus.i_issue_en     = v.ie;
    bus.i_issue_addr   = v.ia;
    bus.i_wr_en        = v.we;
    bus.i_wr_addr      = v.wa;
    bus.i_wr_data      = v.wd;
    bus.i_wr_only_high = v.hi;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    idle();
    bus.i_rd_addr = {3'd7, 3'd2};
    #2;
    chk("rst_d0", 0, {16'h0, bus.o_rd_data[15:0]}, 32'h0);
    chk("rst_d1", 0, {16'h0, bus.o_rd_data[31:16]}, 32'h0);
    chk("rst_busy", 0, {30'h0, bus.o_rd_busy}, 32'h0);
    chk("rst_stall", 0, {31'h0, bus.o_issue_stall}, 32'h0);
    chk("rst_err", 0, {31'h0, bus.o_err}, 32'h0);

    // ra0 ra1 ie ia we wa wd hi | d0 d1 busy stall err
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(2, 3, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(4, 5, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(6, 7, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(2, 2, 1, 2, 1, 2, 16'h8C51, 0,
      BYP ? 16'h8C51 : 16'h0, BYP ? 16'h8C51 : 16'h0, 0, 0, 0));
    tbl.push_back(mk(2, 2, 1, 2, 1, 2, 16'hAB00, 1,
      BYP ? 16'hAB51 : 16'h8C51, BYP ? 16'hAB51 : 16'h8C51, 0, 0, 0));
    tbl.push_back(mk(2, 2, 0, 0, 0, 0, 16'h0, 0, 16'hAB51, 16'hAB51, 0, 0, 0));
    tbl.push_back(mk(3, 3, 1, 3, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(3, 3, 1, 3, 0, 0, 16'h0, 0, 16'h0, 16'h0, 3, 0, 0));
    tbl.push_back(mk(3, 3, 1, 3, 0, 0, 16'h0, 0, 16'h0, 16'h0, 3, 0, 0));
    tbl.push_back(mk(3, 3, 1, 3, 0, 0, 16'h0, 0, 16'h0, 16'h0, 3, 1, 0));
    tbl.push_back(mk(3, 3, 1, 3, 1, 3, 16'h1111, 0,
      BYP ? 16'h1111 : 16'h0, BYP ? 16'h1111 : 16'h0, 3, 1, 0));
    tbl.push_back(mk(3, 3, 0, 0, 1, 3, 16'h2222, 0,
      BYP ? 16'h2222 : 16'h1111, BYP ? 16'h2222 : 16'h1111, 3, 0, 0));
    tbl.push_back(mk(3, 3, 0, 0, 1, 3, 16'h3333, 0,
      BYP ? 16'h3333 : 16'h2222, BYP ? 16'h3333 : 16'h2222,
      BYP ? 2'd0 : 2'd3, 0, 0));
    tbl.push_back(mk(3, 3, 0, 3, 0, 0, 16'h0, 0, 16'h3333, 16'h3333, 0, 0, 0));
    tbl.push_back(mk(5, 5, 1, 5, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(5, 5, 1, 5, 1, 5, 16'h0055, 0,
      BYP ? 16'h0055 : 16'h0, BYP ? 16'h0055 : 16'h0,
      BYP ? 2'd0 : 2'd3, 0, 0));
    tbl.push_back(mk(5, 5, 0, 0, 0, 0, 16'h0, 0, 16'h0055, 16'h0055, 3, 0, 0));
    tbl.push_back(mk(5, 5, 0, 0, 1, 5, 16'h0056, 0,
      BYP ? 16'h0056 : 16'h0055, BYP ? 16'h0056 : 16'h0055,
      BYP ? 2'd0 : 2'd3, 0, 0));
    tbl.push_back(mk(5, 5, 1, 5, 1, 5, 16'h0057, 0,
      BYP ? 16'h0057 : 16'h0056, BYP ? 16'h0057 : 16'h0056, 0, 0, 0));
    tbl.push_back(mk(5, 5, 0, 0, 0, 0, 16'h0, 0, 16'h0057, 16'h0057, 0, 0, 0));
    tbl.push_back(mk(6, 6, 0, 0, 1, 6, 16'h6666, 0,
      BYP ? 16'h6666 : 16'h0, BYP ? 16'h6666 : 16'h0, 0, 0, 0));
    tbl.push_back(mk(6, 6, 0, 0, 0, 0, 16'h0, 0, 16'h6666, 16'h6666, 0, 0, 1));
    tbl.push_back(mk(1, 6, 1, 1, 0, 0, 16'h0, 0, 16'h0, 16'h6666, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16'h1234, 0,
      BYP ? 16'h1234 : 16'h0, 16'h0, BYP ? 2'd0 : 2'd1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 16'h1234, 16'h0, 0, 0, 1));

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q.pop_front();
      chk("d0", i, {16'h0, bus.o_rd_data[15:0]}, {16'h0, e.d0});
      chk("d1", i, {16'h0, bus.o_rd_data[31:16]}, {16'h0, e.d1});
      chk("busy", i, {30'h0, bus.o_rd_busy}, {30'h0, e.b});
      chk("stall", i, {31'h0, bus.o_issue_stall}, {31'h0, e.s});
      chk("err", i, {31'h0, bus.o_err}, {31'h0, e.e});
    end

    // Build pend[R4]=2, then reset between clock edges.
    @(negedge clk);
    drive(mk(4, 4, 1, 4, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(4, 4, 1, 4, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(4, 1, 0, 4, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("r4_busy", 0, {30'h0, bus.o_rd_busy}, 32'h1);
    chk("pre_rst_d1", 0, {16'h0, bus.o_rd_data[31:16]}, 32'h1234);
    chk("pre_rst_err", 0, {31'h0, bus.o_err}, 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 0, {30'h0, bus.o_rd_busy}, 32'h0);
    chk("arst_d1", 0, {16'h0, bus.o_rd_data[31:16]}, 32'h0);
    chk("arst_err", 0, {31'h0, bus.o_err}, 32'h0);
    chk("arst_stall", 0, {31'h0, bus.o_issue_stall}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
